// File: rtl/chan_burst_injector_if.sv
// Symbol stream between the convolutional encoder, the burst-error channel
// model and the Viterbi decoder. The encoder side drives valid_i/sym_i. The
// channel model returns the registered, possibly corrupted symbol together
// with the mask that was applied to it.
interface chan_burst_injector_if;
  logic       valid_i;
  logic [1:0] sym_i;
  logic       valid_o;
  logic [1:0] sym_o;
  logic [1:0] err_mask_o;

  modport master (
    output valid_i,
    output sym_i,
    input  valid_o,
    input  sym_o,
    input  err_mask_o
  );

  modport slave (
    input  valid_i,
    input  sym_i,
    output valid_o,
    output sym_o,
    output err_mask_o
  );
endinterface

// File: rtl/chan_burst_injector.sv
// Burst-error channel model placed between the convolutional encoder and the
// Viterbi decoder.
//
// Each 2-bit symbol is registered and XORed with an error mask. A 32-bit
// Galois LFSR (x^32+x^22+x^2+x+1) decides when a burst starts, and it also
// supplies the mask bits. A burst covers BURST_LEN accepted symbols.
// Corruption is confined to the first WINDOW symbols after reset.
//
// Optional build macro CHAN_STATS_EN enables the burst and flipped-bit
// statistics counters. When the macro is undefined, those two outputs read 0.
// The word counter is always present because it bounds the window.
module chan_burst_injector #(
  parameter int unsigned N         = 5,
  parameter int unsigned BURST_LEN = 2,
  parameter int unsigned WINDOW    = 256,
  parameter logic [31:0] SEED      = 32'hACE1_1234
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inj_en_i,
  chan_burst_injector_if.slave chan_if,
  output logic                 inj_active_o,
  output logic [15:0]          word_ct_o,
  output logic [15:0]          burst_ct_o,
  output logic [15:0]          bad_bit_ct_o
);

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [7:0]  BURST_REM = 8'(BURST_LEN - 1);
  localparam logic [31:0] WIN_END   = 32'(WINDOW);
  localparam logic [31:0] WIN_LAST  = 32'(WINDOW - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  rem_q, rem_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [15:0] word_ct_q, word_ct_d;
  logic        valid_q;
  logic [1:0]  sym_q;
  logic [1:0]  err_mask_q;

  logic [1:0]  mask;
  logic [1:0]  lfsr_mask;
  logic [31:0] sym_idx;
  logic        trigger;
  logic        in_window;
  logic        at_last;
  logic        can_start;

  // Trigger and mask are taken from the LFSR value before it advances.
  assign lfsr_d    = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
  assign trigger   = &lfsr_q[N-1:0];
  // A raw mask of 00 is replaced by 11, so every injected symbol flips at least one bit.
  assign lfsr_mask = (lfsr_q[31:30] == 2'b00) ? 2'b11 : lfsr_q[31:30];

  // word_ct_q is the index of the symbol currently being accepted.
  assign sym_idx   = {16'd0, word_ct_q};
  assign in_window = sym_idx < WIN_END;
  assign at_last   = sym_idx == WIN_LAST;
  assign can_start = in_window && inj_en_i && trigger;
  assign word_ct_d = (word_ct_q == 16'hFFFF) ? word_ct_q : word_ct_q + 16'd1;

  // Next state, burst countdown, and the mask applied to the incoming symbol.
  // NOTE: every signal this block writes gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    mask    = 2'b00;
    if (chan_if.valid_i) begin
      case (state_q)
        ST_IDLE: begin
          if (can_start) begin
            mask  = lfsr_mask;
            rem_d = BURST_REM;
            if (BURST_REM != 8'd0) state_d = ST_BURST;
          end
          // The last symbol of the window closes injection, even if a burst just started on it.
          if (at_last) begin
            state_d = ST_DONE;
            rem_d   = 8'd0;
          end
        end
        ST_BURST: begin
          if (in_window) mask = lfsr_mask;
          rem_d = rem_q - 8'd1;
          if (at_last) begin
            state_d = ST_DONE;
            rem_d   = 8'd0;
          end else if (rem_q == 8'd1) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          // ST_DONE: pure pass-through until reset.
        end
      endcase
    end
  end

  // FSM state and remaining-burst register. Both hold while valid_i is low.
  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rem_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Output stage, LFSR and word counter. LFSR and counter advance only on accepted symbols.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      sym_q      <= 2'b00;
      err_mask_q <= 2'b00;
      lfsr_q     <= SEED;
      word_ct_q  <= 16'd0;
    end else begin
      valid_q    <= chan_if.valid_i;
      err_mask_q <= mask;
      if (chan_if.valid_i) begin
        sym_q     <= chan_if.sym_i ^ mask;
        lfsr_q    <= lfsr_d;
        word_ct_q <= word_ct_d;
      end
    end
  end

`ifdef CHAN_STATS_EN
  logic [15:0] burst_ct_q;
  logic [15:0] bad_bit_ct_q;
  logic [16:0] bad_sum;

  assign bad_sum = {1'b0, bad_bit_ct_q} + 17'(mask[1]) + 17'(mask[0]);

  // Saturating statistics: bursts started and total flipped bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_ct_q   <= 16'd0;
      bad_bit_ct_q <= 16'd0;
    end else if (chan_if.valid_i) begin
      if (state_q == ST_IDLE && can_start && burst_ct_q != 16'hFFFF) begin
        burst_ct_q <= burst_ct_q + 16'd1;
      end
      bad_bit_ct_q <= bad_sum[16] ? 16'hFFFF : bad_sum[15:0];
    end
  end

  assign burst_ct_o   = burst_ct_q;
  assign bad_bit_ct_o = bad_bit_ct_q;
`else
  assign burst_ct_o   = 16'd0;
  assign bad_bit_ct_o = 16'd0;
`endif

  assign chan_if.valid_o    = valid_q;
  assign chan_if.sym_o      = sym_q;
  assign chan_if.err_mask_o = err_mask_q;
  assign inj_active_o       = (state_q == ST_BURST);
  assign word_ct_o          = word_ct_q;

endmodule

// File: tb/tb_chan_burst_injector.sv
// Testbench for chan_burst_injector. It exercises two instances:
//   dut_a: N=1, BURST_LEN=4 (frequent bursts)
//   dut_b: N=2, BURST_LEN=3
// Expected outputs come from a symbol-level model. For each accepted symbol,
// the model decides the mask from the symbol index, the remaining burst
// length and the LFSR value.
module tb_chan_burst_injector;

`ifdef CHAN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int          WINDOW = 256;
  localparam logic [31:0] SEED   = 32'hACE1_1234;
  localparam int          N_A    = 1;
  localparam int          BL_A   = 4;
  localparam int          N_B    = 2;
  localparam int          BL_B   = 3;

  typedef struct packed {
    logic        valid;
    logic [1:0]  sym;
    logic [1:0]  mask;
    logic        active;
    logic [15:0] word;
    logic [15:0] burst;
    logic [15:0] bad;
  } obs_t;

  typedef struct {
    logic [31:0] lfsr;
    int          rem;       // burst symbols still owed
    int          idx;       // symbols accepted so far
    int          bursts;
    int          bad_bits;
    logic [1:0]  last_sym;
  } model_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, en_a, en_b;
  logic        act_a, act_b;
  logic [15:0] wc_a, bc_a, bb_a, wc_b, bc_b, bb_b;

  chan_burst_injector_if if_a ();
  chan_burst_injector_if if_b ();

  chan_burst_injector #(.N(N_A), .BURST_LEN(BL_A), .WINDOW(WINDOW), .SEED(SEED)) dut_a (
    .clk(clk), .rst(rst_a), .inj_en_i(en_a), .chan_if(if_a),
    .inj_active_o(act_a), .word_ct_o(wc_a), .burst_ct_o(bc_a), .bad_bit_ct_o(bb_a)
  );

  chan_burst_injector #(.N(N_B), .BURST_LEN(BL_B), .WINDOW(WINDOW), .SEED(SEED)) dut_b (
    .clk(clk), .rst(rst_b), .inj_en_i(en_b), .chan_if(if_b),
    .inj_active_o(act_b), .word_ct_o(wc_b), .burst_ct_o(bc_b), .bad_bit_ct_o(bb_b)
  );

  model_t mdl [2];
  int     n_cmp  = 0;
  int     n_fail = 0;

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
  endfunction

  function automatic logic [1:0] mask_of(input logic [31:0] x);
    return (x[31:30] == 2'b00) ? 2'b11 : x[31:30];
  endfunction

  function automatic int popc2(input logic [1:0] m);
    return int'(m[0]) + int'(m[1]);
  endfunction

  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("v=%b s=%b m=%b act=%b wc=%0d bc=%0d bb=%0d",
                     o.valid, o.sym, o.mask, o.active, o.word, o.burst, o.bad);
  endfunction

  function automatic obs_t sample(input int inst);
    obs_t o;
    if (inst == 0) begin
      o.valid = if_a.valid_o; o.sym = if_a.sym_o; o.mask = if_a.err_mask_o;
      o.active = act_a; o.word = wc_a; o.burst = bc_a; o.bad = bb_a;
    end else begin
      o.valid = if_b.valid_o; o.sym = if_b.sym_o; o.mask = if_b.err_mask_o;
      o.active = act_b; o.word = wc_b; o.burst = bc_b; o.bad = bb_b;
    end
    return o;
  endfunction

  task automatic model_reset(input int inst);
    mdl[inst].lfsr     = SEED;
    mdl[inst].rem      = 0;
    mdl[inst].idx      = 0;
    mdl[inst].bursts   = 0;
    mdl[inst].bad_bits = 0;
    mdl[inst].last_sym = 2'b00;
  endtask

  // One accepted symbol. Inside the window, an owed burst symbol takes
  // priority; otherwise a new burst may start when enabled and the low n LFSR
  // bits are all ones.
  task automatic model_sym(input int inst, input bit en, input logic [1:0] s,
                           output logic [1:0] m);
    int          n, bl;
    logic [31:0] ones;
    n    = (inst == 0) ? N_A : N_B;
    bl   = (inst == 0) ? BL_A : BL_B;
    ones = (32'd1 << n) - 32'd1;
    m    = 2'b00;
    if (mdl[inst].idx < WINDOW) begin
      if (mdl[inst].rem > 0) begin
        m = mask_of(mdl[inst].lfsr);
        mdl[inst].rem--;
      end else if (en && ((mdl[inst].lfsr & ones) == ones)) begin
        m = mask_of(mdl[inst].lfsr);
        mdl[inst].rem = bl - 1;
        mdl[inst].bursts++;
      end
    end
    mdl[inst].bad_bits += popc2(m);
    mdl[inst].lfsr      = lfsr_next(mdl[inst].lfsr);
    mdl[inst].idx++;
    mdl[inst].last_sym  = s ^ m;
  endtask

  function automatic obs_t expected(input int inst, input bit v, input logic [1:0] m);
    obs_t e;
    e.valid  = v;
    e.mask   = v ? m : 2'b00;
    e.sym    = mdl[inst].last_sym;
    e.active = (mdl[inst].rem > 0) && (mdl[inst].idx < WINDOW);
    e.word   = sat16(mdl[inst].idx);
    e.burst  = STATS ? sat16(mdl[inst].bursts) : 16'd0;
    e.bad    = STATS ? sat16(mdl[inst].bad_bits) : 16'd0;
    return e;
  endfunction

  // Drive one cycle on the falling edge and sample 1 ns after the rising edge.
  task automatic step(input int inst, input bit v, input logic [1:0] s, input bit en,
                      output obs_t got, output obs_t exp);
    logic [1:0] m;
    @(negedge clk);
    if (inst == 0) begin
      if_a.valid_i = v; if_a.sym_i = s; en_a = en;
    end else begin
      if_b.valid_i = v; if_b.sym_i = s; en_b = en;
    end
    @(posedge clk);
    #1;
    got = sample(inst);
    m   = 2'b00;
    if (v) model_sym(inst, en, s, m);
    exp = expected(inst, v, m);
  endtask

  task automatic do_reset(input int inst);
    @(negedge clk);
    if (inst == 0) begin
      rst_a = 1'b0; if_a.valid_i = 1'b0;
    end else begin
      rst_b = 1'b0; if_b.valid_i = 1'b0;
    end
    @(negedge clk);
    if (inst == 0) rst_a = 1'b1; else rst_b = 1'b1;
    model_reset(inst);
  endtask

  task automatic test_reset();
    obs_t got, exp;
    bit   hit;
    @(negedge clk);
    rst_a = 1'b0; if_a.valid_i = 1'b0;
    #1;
    got = sample(0);
    n_cmp++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_initial: got %s, required all zero", fmt(got));
    end
    @(negedge clk);
    rst_a = 1'b1;
    model_reset(0);
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      step(0, 1'b1, 2'($urandom_range(0, 3)), 1'b1, got, exp);
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_pre sym %0d: got %s, required %s", i, fmt(got), fmt(exp));
      end
      hit = got.active;
    end
    n_cmp++;
    if (!hit) begin
      n_fail++;
      $display("FAIL reset_burst_start: inj_active_o never rose within 60 symbols");
    end
    // Asynchronous reset asserted mid-cycle while the burst is in progress.
    #2;
    rst_a = 1'b0; if_a.valid_i = 1'b0;
    #1;
    got = sample(0);
    n_cmp++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_burst: got %s, required all zero", fmt(got));
    end
    @(negedge clk);
    rst_a = 1'b1;
    model_reset(0);
    for (int i = 0; i < 40; i++) begin
      step(0, 1'b1, 2'($urandom_range(0, 3)), 1'b1, got, exp);
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_post sym %0d: got %s, required %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_pass_through();
    obs_t got, exp;
    do_reset(1);
    for (int i = 0; i < 300; i++) begin
      step(1, 1'b1, 2'b10, 1'b0, got, exp);
      n_cmp++;
      if (got !== exp || got.sym !== 2'b10 || got.mask !== 2'b00) begin
        n_fail++;
        $display("FAIL pass_through sym %0d: got %s, required %s", i, fmt(got), fmt(exp));
      end
    end
    n_cmp++;
    if (got.word !== 16'd300 || got.burst !== 16'd0 || got.bad !== 16'd0) begin
      n_fail++;
      $display("FAIL pass_through_counts: got wc=%0d bc=%0d bb=%0d, required wc=300 bc=0 bb=0",
               got.word, got.burst, got.bad);
    end
  endtask

  task automatic test_window();
    obs_t got, exp;
    int   nz_in;
    nz_in = 0;
    do_reset(0);
    for (int i = 0; i < 400; i++) begin
      step(0, 1'b1, 2'($urandom_range(0, 3)), 1'b1, got, exp);
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL window sym %0d: got %s, required %s", i, fmt(got), fmt(exp));
      end
      if (i < WINDOW) begin
        if (got.mask != 2'b00) nz_in++;
      end else begin
        n_cmp++;
        if (got.mask !== 2'b00 || got.active !== 1'b0) begin
          n_fail++;
          $display("FAIL window_bound sym %0d: got m=%b act=%b, required m=00 act=0",
                   i, got.mask, got.active);
        end
      end
    end
    n_cmp++;
    if (nz_in == 0) begin
      n_fail++;
      $display("FAIL window_inject: got 0 corrupted symbols inside window, required >0");
    end
  endtask

  task automatic test_burst_gaps();
    obs_t got, exp;
    do_reset(1);
    for (int i = 0; i < 200; i++) begin
      step(1, 1'b1, 2'($urandom_range(0, 3)), 1'b1, got, exp);
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL burst_gap sym %0d: got %s, required %s", i, fmt(got), fmt(exp));
      end
      for (int g = int'($urandom_range(0, 3)); g > 0; g--) begin
        step(1, 1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), got, exp);
        n_cmp++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL burst_gap idle after %0d: got %s, required %s", i, fmt(got), fmt(exp));
        end
      end
    end
  endtask

  task automatic test_scoreboard();
    obs_t       got, exp;
    logic [1:0] s;
    int         obs_bits;
    obs_bits = 0;
    do_reset(1);
    for (int i = 0; i < 256; i++) begin
      s = 2'($urandom_range(0, 3));
      step(1, 1'b1, s, ($urandom_range(0, 3) != 0), got, exp);
      obs_bits += popc2(s ^ got.sym);
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL scoreboard sym %0d: got %s, required %s", i, fmt(got), fmt(exp));
      end
    end
    n_cmp++;
    if (obs_bits != mdl[1].bad_bits) begin
      n_fail++;
      $display("FAIL scoreboard_flips: got %0d flipped bits on the wire, required %0d",
               obs_bits, mdl[1].bad_bits);
    end
    n_cmp++;
    if (got.bad !== (STATS ? sat16(obs_bits) : 16'd0)) begin
      n_fail++;
      $display("FAIL scoreboard_bad_ct: got %0d, required %0d",
               got.bad, STATS ? obs_bits : 0);
    end
    n_cmp++;
    if (got.burst !== (STATS ? sat16(mdl[1].bursts) : 16'd0)) begin
      n_fail++;
      $display("FAIL scoreboard_burst_ct: got %0d, required %0d",
               got.burst, STATS ? mdl[1].bursts : 0);
    end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b0; en_b = 1'b0;
    if_a.valid_i = 1'b0; if_a.sym_i = 2'b00;
    if_b.valid_i = 1'b0; if_b.sym_i = 2'b00;
    model_reset(0);
    model_reset(1);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    test_reset();
    test_pass_through();
    test_window();
    test_burst_gaps();
    test_scoreboard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
